// File: rtl/management_rx_frame_reader_pkg.sv
// Shared types and constants for the management RX frame reader and its output buffer.
package ManagementRxPkg;

    localparam int MGMT_MAX_FRAME   = 1500;
    localparam int MGMT_LEN_WIDTH   = 11;
    localparam int MGMT_WORDS_WIDTH = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR_WAIT = 3'd1,
        ST_LEN_OUT  = 3'd2,
        ST_DATA     = 3'd3,
        ST_FLUSH    = 3'd4
    } rx_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [2:0]  bytes;
    } rx_beat_t;

    // A zero length remainder means the final word is full.
    function automatic logic [2:0] tail_bytes(input logic [1:0] tail);
        return (tail == 2'd0) ? 3'd4 : {1'b0, tail};
    endfunction

endpackage

// File: rtl/management_rx_frame_reader_skid_buffer.sv
// Two-entry valid/ready buffer for frame data beats; reports occupancy so the
// reader can bound outstanding FIFO reads. A synchronous clear empties it.
module mgmt_rx_skid_buffer
    import ManagementRxPkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_clear,
    input  logic      i_wr_en,
    input  rx_beat_t  i_wr_beat,
    output logic      o_valid,
    input  logic      i_ready,
    output rx_beat_t  o_beat,
    output logic [1:0] o_count
);

    rx_beat_t   r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_pop;

    assign w_pop = (r_count != 2'd0) && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clear) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_wr_en) begin
                r_mem[r_wr_ptr] <= i_wr_beat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_wr_en} - {1'b0, w_pop};
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_beat  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/management_rx_frame_reader.sv
// Reads one length header and its data words per frame from the management RX
// FIFOs and presents them as a length beat followed by data beats.
module management_rx_frame_reader
    import ManagementRxPkg::*;
#(
    parameter int MAX_LEN = MGMT_MAX_FRAME
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic                      fifo_reset,
    input  logic                      rxheader_rd_empty,
    input  logic [MGMT_LEN_WIDTH-1:0] rxheader_rd_data,
    output logic                      rxheader_rd_en,
    input  logic [31:0]               rxfifo_rd_data,
    output logic                      rxfifo_rd_en,
    output logic                      rxfifo_rd_pop_single,
    output logic                      len_valid,
    input  logic                      len_ready,
    output logic [MGMT_LEN_WIDTH-1:0] len_data,
    output logic                      len_oversize,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_data,
    output logic                      out_last,
    output logic [2:0]                out_bytes,
    input  logic                      abort,
    output logic [31:0]               frames_done,
    output logic [31:0]               frames_aborted
);

    localparam logic [MGMT_LEN_WIDTH-1:0] C_MAX_LEN = MGMT_LEN_WIDTH'(MAX_LEN);

    rx_state_e                   r_state;
    logic [MGMT_LEN_WIDTH-1:0]   r_len;
    logic                        r_len_oversize;
    logic                        r_len_valid;
    logic [MGMT_WORDS_WIDTH-1:0] r_words;
    logic [1:0]                  r_tail;
    logic [MGMT_WORDS_WIDTH-1:0] r_to_read;
    logic [MGMT_WORDS_WIDTH-1:0] r_word_idx;
    logic                        r_inflight;
    logic [31:0]                 r_frames_done;
    logic [31:0]                 r_frames_aborted;

    logic                        w_clamp;
    logic [MGMT_LEN_WIDTH-1:0]   w_len_cl;
    logic [MGMT_LEN_WIDTH:0]     w_len_p3;
    logic [MGMT_WORDS_WIDTH-1:0] w_words;
    logic                        w_len_hs;
    logic                        w_buf_valid;
    rx_beat_t                    w_buf_beat;
    logic [1:0]                  w_buf_count;
    logic                        w_pop;
    logic                        w_last_accept;
    logic [2:0]                  w_occupancy;
    logic                        w_rd_data;
    logic                        w_buf_wr;
    logic                        w_abort_take;
    logic                        w_buf_clear;
    logic                        w_wr_last;
    rx_beat_t                    w_wr_beat;

    assign w_clamp  = rxheader_rd_data > C_MAX_LEN;
    assign w_len_cl = w_clamp ? C_MAX_LEN : rxheader_rd_data;
    assign w_len_p3 = {1'b0, w_len_cl} + 12'd3;
    assign w_words  = w_len_p3[MGMT_LEN_WIDTH:2];

    assign w_len_hs      = r_len_valid && len_ready;
    assign w_pop         = w_buf_valid && out_ready;
    assign w_last_accept = w_pop && w_buf_beat.last;

    // Credit: words held after this cycle's accept plus the word still in flight.
    assign w_occupancy = {1'b0, w_buf_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign w_rd_data = !fifo_reset && (r_to_read != '0) &&
                       (((r_state == ST_DATA) && (w_occupancy < 3'd2)) || (r_state == ST_FLUSH));
    assign w_buf_wr  = r_inflight && (r_state == ST_DATA) && !fifo_reset;

    // Accepting the frame's final beat takes precedence over a coincident abort.
    assign w_abort_take = abort &&
                          (((r_state == ST_LEN_OUT) && !(w_len_hs && (r_words == '0))) ||
                           ((r_state == ST_DATA) && !w_last_accept));
    assign w_buf_clear  = fifo_reset || w_abort_take || (r_state == ST_FLUSH);

    assign w_wr_last       = (r_word_idx == (r_words - 10'd1));
    assign w_wr_beat.data  = rxfifo_rd_data;
    assign w_wr_beat.last  = w_wr_last;
    assign w_wr_beat.bytes = w_wr_last ? tail_bytes(r_tail) : 3'd4;

    assign rxheader_rd_en = (r_state == ST_IDLE) && !rxheader_rd_empty && !fifo_reset;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_len            <= '0;
            r_len_oversize   <= 1'b0;
            r_len_valid      <= 1'b0;
            r_words          <= '0;
            r_tail           <= 2'd0;
            r_to_read        <= '0;
            r_word_idx       <= '0;
            r_inflight       <= 1'b0;
            r_frames_done    <= '0;
            r_frames_aborted <= '0;
        end else if (fifo_reset) begin
            r_state     <= ST_IDLE;
            r_len_valid <= 1'b0;
            r_to_read   <= '0;
            r_word_idx  <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_rd_data;
            if (w_rd_data) begin
                r_to_read <= r_to_read - 10'd1;
            end
            if (w_buf_wr) begin
                r_word_idx <= r_word_idx + 10'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!rxheader_rd_empty) begin
                        r_state <= ST_HDR_WAIT;
                    end
                end
                ST_HDR_WAIT: begin
                    r_len          <= w_len_cl;
                    r_len_oversize <= w_clamp;
                    r_words        <= w_words;
                    r_tail         <= w_len_cl[1:0];
                    r_to_read      <= w_words;
                    r_word_idx     <= '0;
                    r_len_valid    <= 1'b1;
                    r_state        <= ST_LEN_OUT;
                end
                ST_LEN_OUT: begin
                    if (w_len_hs && (r_words == '0)) begin
                        r_len_valid   <= 1'b0;
                        r_frames_done <= r_frames_done + 32'd1;
                        r_state       <= ST_IDLE;
                    end else if (w_abort_take) begin
                        r_len_valid <= 1'b0;
                        r_state     <= ST_FLUSH;
                    end else if (w_len_hs) begin
                        r_len_valid <= 1'b0;
                        r_state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_last_accept) begin
                        r_frames_done <= r_frames_done + 32'd1;
                        r_state       <= ST_IDLE;
                    end else if (w_abort_take) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (r_to_read == '0) begin
                        r_frames_aborted <= r_frames_aborted + 32'd1;
                        r_state          <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    mgmt_rx_skid_buffer u_buf (
        .clk       (sys_clk),
        .rst_n     (rst_n),
        .i_clear   (w_buf_clear),
        .i_wr_en   (w_buf_wr),
        .i_wr_beat (w_wr_beat),
        .o_valid   (w_buf_valid),
        .i_ready   (out_ready),
        .o_beat    (w_buf_beat),
        .o_count   (w_buf_count)
    );

    assign rxfifo_rd_en         = w_rd_data;
    assign rxfifo_rd_pop_single = w_rd_data;
    assign len_valid            = r_len_valid;
    assign len_data             = r_len;
    assign len_oversize         = r_len_oversize;
    assign out_valid            = w_buf_valid;
    assign out_data             = w_buf_beat.data;
    assign out_last             = w_buf_beat.last;
    assign out_bytes            = w_buf_beat.bytes;
    assign frames_done          = r_frames_done;
    assign frames_aborted       = r_frames_aborted;

endmodule

// File: tb/tb_management_rx_frame_reader.sv
// Self-checking bench: queue-based FIFO model feeds the reader, captured beats are
// compared against frames built from length/word rules.
module tb_management_rx_frame_reader;
    import ManagementRxPkg::*;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_reset = 1'b0;
    logic        rxheader_rd_empty = 1'b1;
    logic [10:0] rxheader_rd_data = '0;
    logic        rxheader_rd_en;
    logic [31:0] rxfifo_rd_data = '0;
    logic        rxfifo_rd_en;
    logic        rxfifo_rd_pop_single;
    logic        len_valid;
    logic        len_ready = 1'b0;
    logic [10:0] len_data;
    logic        len_oversize;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic [2:0]  out_bytes;
    logic        abort = 1'b0;
    logic [31:0] frames_done;
    logic [31:0] frames_aborted;

    always #5 sys_clk = ~sys_clk;

    management_rx_frame_reader #(.MAX_LEN(1500)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .fifo_reset(fifo_reset),
        .rxheader_rd_empty(rxheader_rd_empty), .rxheader_rd_data(rxheader_rd_data),
        .rxheader_rd_en(rxheader_rd_en), .rxfifo_rd_data(rxfifo_rd_data),
        .rxfifo_rd_en(rxfifo_rd_en), .rxfifo_rd_pop_single(rxfifo_rd_pop_single),
        .len_valid(len_valid), .len_ready(len_ready), .len_data(len_data),
        .len_oversize(len_oversize), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_bytes(out_bytes),
        .abort(abort), .frames_done(frames_done), .frames_aborted(frames_aborted)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rd_pulses = 0;
    int strobes_in_reset = 0;
    int pop_single_err = 0;
    int ready_pct = 100;

    logic [10:0] hdr_q[$];
    logic [31:0] dat_q[$];
    logic [10:0] got_len[$];
    logic        got_ovs[$];
    logic [31:0] got_data[$];
    logic        got_last[$];
    logic [2:0]  got_bytes[$];
    int          got_cyc[$];

    // FIFO read side: data appears the cycle after the strobe.
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (rxheader_rd_en && hdr_q.size() != 0) rxheader_rd_data <= hdr_q.pop_front();
        if (rxfifo_rd_en) begin
            rd_pulses <= rd_pulses + 1;
            if (dat_q.size() != 0) rxfifo_rd_data <= dat_q.pop_front();
            else rxfifo_rd_data <= 32'hDEAD_BEEF;
        end
        rxheader_rd_empty <= (hdr_q.size() == 0);
    end

    always @(negedge sys_clk) begin
        if (len_valid && len_ready) begin
            got_len.push_back(len_data);
            got_ovs.push_back(len_oversize);
        end
        if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
            got_bytes.push_back(out_bytes);
            got_cyc.push_back(cyc);
        end
        if (fifo_reset && (rxfifo_rd_en || rxheader_rd_en)) strobes_in_reset++;
        if (rxfifo_rd_pop_single !== rxfifo_rd_en) pop_single_err++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        out_ready = (int'($urandom_range(0, 99)) < ready_pct);
        len_ready = (int'($urandom_range(0, 99)) < ready_pct);
    endtask

    task automatic clear_got();
        got_len.delete(); got_ovs.delete(); got_data.delete();
        got_last.delete(); got_bytes.delete(); got_cyc.delete();
    endtask

    // Reference rules: clamp to 1500, ceil(len/4) words, remainder bytes on the last word.
    function automatic int ref_clamp(input int len);
        return (len > 1500) ? 1500 : len;
    endfunction
    function automatic int ref_beats(input int len);
        return (ref_clamp(len) + 3) / 4;
    endfunction
    function automatic int ref_lastb(input int len);
        return (ref_beats(len) == 0) ? 0 : ref_clamp(len) - 4 * (ref_beats(len) - 1);
    endfunction

    task automatic run_frame(input string tag, input int len, input int pct, input int e_len,
                             input bit e_ovs, input int e_beats, input int e_lastb);
        logic [31:0] exp_w[$];
        logic [31:0] w;
        int p0, fd0, n, errs;
        clear_got();
        p0  = rd_pulses;
        fd0 = int'(frames_done);
        for (int i = 0; i < e_beats; i++) begin
            w = $urandom;
            exp_w.push_back(w);
            dat_q.push_back(w);
        end
        ready_pct = pct;
        hdr_q.push_back(11'(len));
        n = 0;
        while (int'(frames_done) == fd0 && n < 20000) begin
            tick();
            n++;
        end
        check({tag, " timeout"}, 32'(n < 20000), 32'd1);
        check({tag, " len beats"}, 32'(got_len.size()), 32'd1);
        if (got_len.size() != 0) begin
            check({tag, " len_data"}, 32'(got_len[0]), 32'(e_len));
            check({tag, " len_oversize"}, 32'(got_ovs[0]), 32'(e_ovs));
        end
        check({tag, " beats"}, 32'(got_data.size()), 32'(e_beats));
        errs = 0;
        for (int i = 0; i < got_data.size() && i < e_beats; i++) begin
            logic       el;
            logic [2:0] eb;
            el = (i == e_beats - 1);
            eb = el ? 3'(e_lastb) : 3'd4;
            if (got_data[i] !== exp_w[i] || got_last[i] !== el || got_bytes[i] !== eb) errs++;
        end
        check({tag, " bad words"}, 32'(errs), 32'd0);
        check({tag, " data pops"}, 32'(rd_pulses - p0), 32'(e_beats));
        check({tag, " frames_done"}, frames_done, 32'(fd0 + 1));
        if (pct == 100 && e_beats > 1 && got_cyc.size() == e_beats)
            check({tag, " burst cycles"}, 32'(got_cyc[e_beats-1] - got_cyc[0]), 32'(e_beats - 1));
        $display("frame %s len=%0d beats=%0d pops=%0d", tag, len, got_data.size(), rd_pulses - p0);
    endtask

    typedef struct {
        int len;
        int pct;
        int e_len;
        bit e_ovs;
        int e_beats;
        int e_lastb;
    } vec_t;

    initial begin
        vec_t vecs[8];
        logic [31:0] aw[$];
        logic [31:0] w;
        int n, p0, fd0, fa0, len;

        vecs[0] = '{64,   100, 64,   1'b0, 16,  4};
        vecs[1] = '{61,   100, 61,   1'b0, 16,  1};
        vecs[2] = '{1500, 30,  1500, 1'b0, 375, 4};
        vecs[3] = '{2000, 100, 1500, 1'b1, 375, 4};
        vecs[4] = '{0,    100, 0,    1'b0, 0,   0};
        vecs[5] = '{1,    50,  1,    1'b0, 1,   1};
        vecs[6] = '{7,    70,  7,    1'b0, 2,   3};
        vecs[7] = '{10,   100, 10,   1'b0, 3,   2};

        repeat (3) @(posedge sys_clk);
        #1 rst_n = 1'b1;
        tick();
        check("rst len_valid", 32'(len_valid), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst rd strobes", 32'({rxheader_rd_en, rxfifo_rd_en}), 32'd0);
        check("rst len_data", 32'(len_data), 32'd0);
        check("rst out fields", {out_data[28:0], out_last, out_bytes[1:0]} | {29'd0, out_bytes[2], 2'd0}, 32'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst len_oversize", 32'(len_oversize), 32'd0);
        check("rst frames_done", frames_done, 32'd0);
        check("rst frames_aborted", frames_aborted, 32'd0);

        for (int v = 0; v < 8; v++)
            run_frame($sformatf("vec%0d", v), vecs[v].len, vecs[v].pct, vecs[v].e_len,
                      vecs[v].e_ovs, vecs[v].e_beats, vecs[v].e_lastb);

        // Abort after three beats of a 40-byte frame.
        clear_got();
        ready_pct = 100;
        p0  = rd_pulses;
        fd0 = int'(frames_done);
        fa0 = int'(frames_aborted);
        for (int i = 0; i < 10; i++) begin
            w = $urandom;
            aw.push_back(w);
            dat_q.push_back(w);
        end
        hdr_q.push_back(11'd40);
        n = 0;
        while (got_data.size() < 3 && n < 2000) begin tick(); n++; end
        check("abort reach 3 beats", 32'(n < 2000), 32'd1);
        ready_pct = 0;
        out_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ready_pct = 100;
        n = 0;
        while (int'(frames_aborted) == fa0 && n < 2000) begin tick(); n++; end
        check("abort timeout", 32'(n < 2000), 32'd1);
        check("abort beats", 32'(got_data.size()), 32'd3);
        n = 0;
        for (int i = 0; i < 3 && i < got_data.size(); i++) if (got_data[i] !== aw[i]) n++;
        check("abort early words", 32'(n), 32'd0);
        check("abort pops", 32'(rd_pulses - p0), 32'd10);
        check("abort fifo drained", 32'(dat_q.size()), 32'd0);
        check("abort frames_aborted", frames_aborted, 32'(fa0 + 1));
        check("abort frames_done", frames_done, 32'(fd0));
        $display("abort frame beats=%0d pops=%0d", got_data.size(), rd_pulses - p0);
        run_frame("post_abort", 8, 100, 8, 1'b0, 2, 4);

        // fifo_reset at word 5 of a 100-byte frame.
        clear_got();
        fd0 = int'(frames_done);
        fa0 = int'(frames_aborted);
        for (int i = 0; i < 25; i++) dat_q.push_back($urandom);
        hdr_q.push_back(11'd100);
        n = 0;
        while (got_data.size() < 5 && n < 2000) begin tick(); n++; end
        check("frst reach 5 beats", 32'(n < 2000), 32'd1);
        fifo_reset = 1'b1;
        hdr_q.delete();
        dat_q.delete();
        repeat (3) tick();
        fifo_reset = 1'b0;
        check("frst state idle", 32'(dut.r_state), 32'(ST_IDLE));
        check("frst strobes", 32'(strobes_in_reset), 32'd0);
        check("frst out_valid", 32'(out_valid), 32'd0);
        check("frst len_valid", 32'(len_valid), 32'd0);
        check("frst counters", frames_done + frames_aborted, 32'(fd0 + fa0));
        $display("fifo_reset frame beats=%0d", got_data.size());
        run_frame("post_frst", 12, 100, 12, 1'b0, 3, 4);

        for (int r = 0; r < 6; r++) begin
            len = int'($urandom_range(0, 1700));
            run_frame($sformatf("rnd%0d", r), len, int'($urandom_range(25, 100)),
                      ref_clamp(len), len > 1500, ref_beats(len), ref_lastb(len));
        end

        check("pop_single mirror", 32'(pop_single_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
